// File: rtl/alu_pkg.sv
// Shared types for the ALU operation arbiter: opcode and FSM state encodings.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr_i, wrapping modulo N. Grants nothing when en_i is low.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic found;
    int   idx;

    // Priority search starting at the pointer, first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (en_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/xor_block.sv
// Bitwise XOR with optional inversion of the result (XNOR when invert_i is set).
module xor_block #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             invert_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = (a_i ^ b_i) ^ {WIDTH{invert_i}};

endmodule

// File: rtl/alu_op_arbiter.sv
// Shares one bitwise ALU between NUM_REQ requesters with round-robin
// arbitration. One op in flight: IDLE grants, EXEC computes, RESP presents.
module alu_op_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_zero,
    output logic                     busy
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   xor_y;
    logic [WIDTH-1:0]   alu_y;
    int                 sel;

    // Arbitration is only live in IDLE and held off while reset is asserted.
    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .en_i        ((state_q == IDLE) && !rst),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    xor_block #(.WIDTH(WIDTH)) u_xor_block (
        .a_i      (a_q),
        .b_i      (b_q),
        .invert_i (op_q[0]),
        .y_o      (xor_y)
    );

    // ALU datapath: AND/OR inline, XOR/XNOR from the shared xor_block.
    always_comb begin
        unique case (op_q)
            OP_AND:  alu_y = a_q & b_q;
            OP_OR:   alu_y = a_q | b_q;
            default: alu_y = xor_y;
        endcase
    end

    // Next-state logic: capture the winner in IDLE, compute in EXEC, hold in RESP.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        result_d = result_q;
        zero_d   = zero_q;
        sel      = int'(grant_idx);
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    op_d    = alu_op_e'(req_op[2*sel +: 2]);
                    a_d     = req_a[WIDTH*sel +: WIDTH];
                    b_d     = req_b[WIDTH*sel +: WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_y;
                zero_d   = (alu_y == '0);
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its _d value from before the clock edge.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = result_q;
    assign rsp_zero  = zero_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter: single ops, opcode coverage, fairness,
// pointer wrap, response backpressure and reset mid-operation.
module tb_alu_op_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [1:0]               rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_zero;
    logic                     busy;

    int n_vec  = 0;
    int n_miss = 0;

    alu_op_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    // One full transaction with rsp_ready high, starting in IDLE.
    task automatic run_op(input logic [3:0] mask, input int exp_g, input logic [7:0] exp_d,
                          input logic exp_z, input string tag);
        logic [3:0] onehot;
        onehot    = 4'b0001 << exp_g;
        req_valid = mask;
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(onehot));
        tick();
        req_valid = '0;
        check({tag, "_exec_busy"}, 32'(busy), 32'd1);
        check({tag, "_exec_rspv"}, 32'(rsp_valid), 32'd0);
        tick();
        check({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"}, 32'(rsp_id), 32'(exp_g));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_z));
        tick();
        check({tag, "_idle_rspv"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] fa [4];
        logic [7:0] fe [4];
        fa = '{8'h00, 8'h11, 8'h22, 8'h33};
        fe = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_zero", 32'(rsp_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single XOR from requester 1; payload changes after acceptance.
        set_req(1, 2'b10, 8'hA5, 8'h0F);
        req_valid = 4'b0010;
        #1;
        check("t1_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        set_req(1, 2'b00, 8'h00, 8'hFF);
        check("t1_exec_busy", 32'(busy), 32'd1);
        check("t1_exec_rspv", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_rspv", 32'(rsp_valid), 32'd1);
        check("t1_id", 32'(rsp_id), 32'd1);
        check("t1_data", 32'(rsp_data), 32'hAA);
        check("t1_zero", 32'(rsp_zero), 32'd0);
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Opcode coverage.
        set_req(2, 2'b10, 8'h3C, 8'h3C);
        run_op(4'b0100, 2, 8'h00, 1'b1, "xor_eq");
        set_req(3, 2'b11, 8'h3C, 8'h3C);
        run_op(4'b1000, 3, 8'hFF, 1'b0, "xnor_eq");
        set_req(0, 2'b00, 8'hF0, 8'h3C);
        run_op(4'b0001, 0, 8'h30, 1'b0, "and");
        set_req(1, 2'b01, 8'hF0, 8'h3C);
        run_op(4'b0010, 1, 8'hFC, 1'b0, "or");

        // Fairness from ptr=0 with all four requesters held valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 2'b10, fa[i], 8'h0F);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fair%0d_grant", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("fair%0d_exec_ready", k), 32'(req_ready), 32'd0);
            tick();
            check($sformatf("fair%0d_rspv", k), 32'(rsp_valid), 32'd1);
            check($sformatf("fair%0d_id", k), 32'(rsp_id), 32'(k % 4));
            check($sformatf("fair%0d_data", k), 32'(rsp_data), 32'(fe[k % 4]));
            tick();
            check($sformatf("fair%0d_idle_rspv", k), 32'(rsp_valid), 32'd0);
        end
        req_valid = '0;

        // Pointer wrap: grant 2 (ptr=3), then lone req 0 wraps ptr to 1.
        set_req(2, 2'b10, 8'h55, 8'hFF);
        run_op(4'b0100, 2, 8'hAA, 1'b0, "wrap_g2");
        set_req(0, 2'b00, 8'hC3, 8'h81);
        run_op(4'b0001, 0, 8'h81, 1'b0, "wrap_g0");
        set_req(1, 2'b11, 8'hF0, 8'h0F);
        run_op(4'b0011, 1, 8'h00, 1'b1, "wrap_g1");

        // Backpressure in RESP with other requests pending (ptr=2).
        rsp_ready = 1'b0;
        set_req(3, 2'b01, 8'h81, 8'h42);
        req_valid = 4'b1000;
        #1;
        check("bp_grant", 32'(req_ready), 32'h8);
        tick();
        set_req(0, 2'b00, 8'hFF, 8'h5A);
        req_valid = 4'b0111;
        tick();
        for (int j = 0; j < 5; j++) begin
            check($sformatf("bp%0d_rspv", j), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_id", j), 32'(rsp_id), 32'd3);
            check($sformatf("bp%0d_data", j), 32'(rsp_data), 32'hC3);
            check($sformatf("bp%0d_ready", j), 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_rspv", 32'(rsp_valid), 32'd1);
        tick();
        check("bp_idle_rspv", 32'(rsp_valid), 32'd0);
        check("bp_idle_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        check("bp_next_id", 32'(rsp_id), 32'd0);
        check("bp_next_data", 32'(rsp_data), 32'h5A);
        tick();

        // Reset asserted mid-EXEC (ptr=1 before the op).
        set_req(2, 2'b10, 8'h12, 8'h34);
        req_valid = 4'b0100;
        #1;
        check("mid_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rspv", 32'(rsp_valid), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_data", 32'(rsp_data), 32'd0);
        check("mid_rst_zero", 32'(rsp_zero), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("post_rst%0d_rspv", j), 32'(rsp_valid), 32'd0);
            check($sformatf("post_rst%0d_busy", j), 32'(busy), 32'd0);
            tick();
        end
        set_req(0, 2'b01, 8'h0F, 8'hF0);
        set_req(1, 2'b00, 8'hFF, 8'hFF);
        run_op(4'b0011, 0, 8'hFF, 1'b0, "post_rst_op");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
- Shares one ALU datapath (AND/OR/XOR/XNOR) between NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel; all requesters share one valid/ready response channel that carries the winner's ID.
- Sits between client engines and the ALU. Registers operands and result, so the ALU logic stays purely combinational.
- One operation in flight at a time.

Parameters:
- NUM_REQ, 4: number of requesters. Must be >= 2.
- WIDTH, 8: operand and result width in bits.
- ID_W, $clog2(NUM_REQ): requester ID width. Derived localparam; not user-overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i = requester i has an operation pending.
- req_ready  out  NUM_REQ  one-hot grant/accept; bit i = request i is taken this cycle.
- req_op  in  2*NUM_REQ  packed 2-bit opcode per requester: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- req_a  in  WIDTH*NUM_REQ  packed operand A per requester.
- req_b  in  WIDTH*NUM_REQ  packed operand B per requester.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that issued this result.
- rsp_data  out  WIDTH  result.
- rsp_zero  out  1  high when rsp_data == 0.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset puts the FSM in IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, busy=0, RR pointer=0, operand/opcode registers=0.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first asserted req_valid bit, searching from ptr upward and wrapping modulo NUM_REQ.
  - req_ready is all-zero if no req_valid bit is set.
  - On a grant g: capture req_op[g], req_a[g], req_b[g] and g; set ptr <= (g+1) mod NUM_REQ; go to EXEC.
- EXEC (exactly 1 cycle):
  - result register <= ALU(op, a, b).
  - XOR/XNOR use the existing xor_block with invert = op[0].
  - zero flag <= (result == 0).
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_zero are held stable until rsp_ready is sampled high.
  - On rsp_valid & rsp_ready, go to IDLE.
  - req_ready=0 throughout.
- Latency: request accepted in cycle N gives rsp_valid in cycle N+2. Peak throughput is one op per 3 cycles with rsp_ready tied high.
- req_ready is 0 in EXEC and RESP. Requests must hold valid and payload until accepted; this block never drops a pending request.
- Fairness:
  - The pointer advances only on a grant. It never moves while idle with no requests.
  - A continuously valid requester waits at most NUM_REQ-1 grants.
- Arithmetic: bitwise only, no carry. Results are exactly WIDTH bits.
- Bus slicing: requester i's operands are req_a[i*WIDTH +: WIDTH] and req_b[i*WIDTH +: WIDTH]; its opcode is req_op[2*i +: 2].
- Boundary cases:
  - Pointer at NUM_REQ-1 with only requester 0 valid: grant 0 and wrap ptr to 1.
  - Payload that changes after acceptance has no effect on the in-flight op.
  - Reset asserted in any state (mid-EXEC or mid-RESP): the in-flight op is discarded, all outputs take reset values immediately, and no response is emitted after reset deasserts.
- busy = (state != IDLE).

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_XNOR=2'b11).
  - arb_state_e enum (IDLE, EXEC, RESP).
- Sub-module rr_arbiter #(N):
  - Inputs: req, ptr, en.
  - Output: one-hot grant plus encoded grant index.
  - Purely combinational. Reusable by other shared-resource blocks.
- The ALU datapath is inline: an AND/OR mux plus an xor_block instance.

Test Plan:
- Single XOR: requester 1 sends op=10, a=8'hA5, b=8'h0F in cycle 0 -> req_ready=4'b0010 in cycle 0; rsp_valid in cycle 2 with rsp_id=1, rsp_data=8'hAA, rsp_zero=0.
- XOR vs XNOR: a=b=8'h3C. XOR -> rsp_data=8'h00, rsp_zero=1. XNOR -> 8'hFF, rsp_zero=0. AND 8'hF0,8'h3C -> 8'h30. OR -> 8'hFC.
- Fairness: all 4 requesters hold valid for 8 ops with rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3 and responses every 3 cycles.
- Wrap: after granting 3 (ptr=0), then granting 2 (ptr=3), only req 0 valid -> grant 0 and ptr becomes 1. Next, reqs 0 and 1 valid -> grant 1.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid/id/data stable, req_ready=0 with requests pending. rsp_ready high -> IDLE next cycle, new grant that cycle.
- Reset mid-op: assert rst in EXEC for 1 cycle -> outputs go to reset values immediately, no rsp_valid after release. Next request from 0 is granted with ptr=0.
